// File: rtl/encoder_4x2_rr.sv
`default_nettype none
// encoder_4x2_rr: latches request pulses and grants one pending line per
// valid/ready transaction by round-robin (or fixed) priority.
module encoder_4x2_rr #(
  parameter bit RR_EN  = 1'b1,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [3:0]        req_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [1:0]        out_idx,
  output logic [3:0]        out_onehot,
  output logic [3:0]        pending,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int SUM_W = DROP_W + 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        pending_q, pending_d;
  logic [3:0]        onehot_q, onehot_d;
  logic [1:0]        idx_q, idx_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              handshake;
  logic [3:0]        clr;
  logic [3:0]        rem;
  logic [3:0]        drops;
  logic [2:0]        drop_num;
  logic [SUM_W-1:0]  drop_sum;

  // First set bit of vec, scanning upward from start and wrapping at 3.
  function automatic logic [1:0] rr_pick(input logic [3:0] vec, input logic [1:0] start);
    logic [1:0] pick;
    logic [1:0] j;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      j = start + 2'(k);
      if (!found && vec[j]) begin
        pick  = j;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign handshake = (state_q == S_VALID) && out_ready;
  assign clr       = handshake ? onehot_q : 4'b0000;
  assign rem       = pending_q & ~clr;
  // Set wins over clear, so a re-request of the granted line stays pending.
  assign pending_d = rem | req_in;
  assign drops     = req_in & rem;
  assign drop_num  = {2'b00, drops[0]} + {2'b00, drops[1]}
                   + {2'b00, drops[2]} + {2'b00, drops[3]};
  assign drop_sum  = {1'b0, drop_q} + SUM_W'(drop_num);
  assign drop_d    = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    ptr_d    = ptr_q;
    case (state_q)
      S_IDLE: begin
        if (en && (pending_q != 4'b0000)) begin
          idx_d    = rr_pick(pending_q, ptr_q);
          onehot_d = 4'b0001 << idx_d;
          state_d  = S_VALID;
        end
      end
      S_VALID: begin
        if (out_ready) begin
          ptr_d = RR_EN ? (idx_q + 2'd1) : 2'd0;
          if (en && (rem != 4'b0000)) begin
            idx_d    = rr_pick(rem, ptr_d);
            onehot_d = 4'b0001 << idx_d;
          end else begin
            onehot_d = 4'b0000;
            state_d  = S_IDLE;
          end
        end
      end
      default: begin
        onehot_d = 4'b0000;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pending_q <= 4'b0000;
      onehot_q  <= 4'b0000;
      idx_q     <= 2'd0;
      ptr_q     <= 2'd0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      onehot_q  <= onehot_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      drop_q    <= drop_d;
    end
  end

  assign out_valid  = (state_q == S_VALID);
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;
  assign pending    = pending_q;
  assign drop_cnt   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_4x2_rr.sv
`default_nettype none
// Bench for encoder_4x2_rr: vector table, directed corner sequences and a
// randomized run, with a round-robin and a fixed-priority instance side by side.
module tb_encoder_4x2_rr;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req_in;
  logic       out_ready;

  logic       v_rr, v_fx;
  logic [1:0] idx_rr, idx_fx;
  logic [3:0] oh_rr, oh_fx;
  logic [3:0] pend_rr, pend_fx;
  logic [7:0] drop_rr, drop_fx;

  int n_checks = 0;
  int n_fail   = 0;

  encoder_4x2_rr #(.RR_EN(1'b1), .DROP_W(8)) u_rr (
    .clk(clk), .rst_n(rst_n), .en(en), .req_in(req_in), .out_ready(out_ready),
    .out_valid(v_rr), .out_idx(idx_rr), .out_onehot(oh_rr),
    .pending(pend_rr), .drop_cnt(drop_rr)
  );

  encoder_4x2_rr #(.RR_EN(1'b0), .DROP_W(8)) u_fx (
    .clk(clk), .rst_n(rst_n), .en(en), .req_in(req_in), .out_ready(out_ready),
    .out_valid(v_fx), .out_idx(idx_fx), .out_onehot(oh_fx),
    .pending(pend_fx), .drop_cnt(drop_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain description of the grant/pending/drop rules.
  typedef struct packed {
    logic [3:0] pend;
    logic       v;
    logic [1:0] idx;
    logic [1:0] ptr;
    logic [7:0] drop;
  } model_t;

  model_t m_rr, m_fx;

  function automatic logic [1:0] first_from(input logic [3:0] bits, input logic [1:0] p);
    for (int k = 0; k < 4; k++) begin
      int j;
      j = (int'(p) + k) % 4;
      if (bits[j]) return 2'(j);
    end
    return 2'd0;
  endfunction

  function automatic model_t step(input model_t m, input bit rr, input logic e,
                                  input logic [3:0] req, input logic rdy);
    model_t     n;
    int         nd;
    logic [3:0] keep;
    bit         g;
    n    = m;
    g    = m.v && rdy;
    keep = m.pend;
    if (g) keep[m.idx] = 1'b0;
    nd = int'(m.drop);
    for (int i = 0; i < 4; i++) if (req[i] && keep[i]) nd++;
    if (nd > 255) nd = 255;
    n.drop = 8'(nd);
    n.pend = keep | req;
    if (m.v) begin
      if (g) begin
        n.ptr = rr ? 2'((int'(m.idx) + 1) % 4) : 2'd0;
        if (e && keep != 4'b0000) n.idx = first_from(keep, n.ptr);
        else                      n.v   = 1'b0;
      end
    end else if (e && m.pend != 4'b0000) begin
      n.v   = 1'b1;
      n.idx = first_from(m.pend, m.ptr);
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rr <= '0;
      m_fx <= '0;
    end else begin
      m_rr <= step(m_rr, 1'b1, en, req_in, out_ready);
      m_fx <= step(m_fx, 1'b0, en, req_in, out_ready);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("model_rr_valid", 32'(v_rr), 32'(m_rr.v));
    chk("model_rr_idx", 32'(idx_rr), 32'(m_rr.idx));
    chk("model_rr_onehot", 32'(oh_rr), m_rr.v ? 32'(4'b0001 << m_rr.idx) : 32'd0);
    chk("model_rr_pending", 32'(pend_rr), 32'(m_rr.pend));
    chk("model_rr_drop", 32'(drop_rr), 32'(m_rr.drop));
    chk("model_fx_valid", 32'(v_fx), 32'(m_fx.v));
    chk("model_fx_idx", 32'(idx_fx), 32'(m_fx.idx));
    chk("model_fx_onehot", 32'(oh_fx), m_fx.v ? 32'(4'b0001 << m_fx.idx) : 32'd0);
    chk("model_fx_pending", 32'(pend_fx), 32'(m_fx.pend));
    chk("model_fx_drop", 32'(drop_fx), 32'(m_fx.drop));
  endtask

  // Advance to the next falling edge and compare both DUTs to the model.
  task automatic tick();
    @(negedge clk);
    if (rst_n) check_models();
  endtask

  task automatic exp_out(input string nm, input bit fx, input logic v, input logic [1:0] idx,
                         input logic [3:0] oh, input logic [3:0] pend);
    chk({nm, "_valid"},   32'(fx ? v_fx : v_rr), 32'(v));
    if (v) chk({nm, "_idx"}, 32'(fx ? idx_fx : idx_rr), 32'(idx));
    chk({nm, "_onehot"},  32'(fx ? oh_fx : oh_rr), 32'(oh));
    chk({nm, "_pending"}, 32'(fx ? pend_fx : pend_rr), 32'(pend));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_in    = 4'b0000;
    en        = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic       v;
    logic [1:0] idx;
    logic [3:0] oh;
    logic [3:0] pend;
  } vec_t;

  vec_t tbl[10];

  initial begin
    // Round-robin sweep: check the row, then drive its request for the next edge.
    tbl[0] = '{4'b1111, 1'b0, 2'd0, 4'b0000, 4'b0000};
    tbl[1] = '{4'b0000, 1'b0, 2'd0, 4'b0000, 4'b1111};
    tbl[2] = '{4'b0000, 1'b1, 2'd0, 4'b0001, 4'b1111};
    tbl[3] = '{4'b0000, 1'b1, 2'd1, 4'b0010, 4'b1110};
    tbl[4] = '{4'b0000, 1'b1, 2'd2, 4'b0100, 4'b1100};
    tbl[5] = '{4'b1001, 1'b1, 2'd3, 4'b1000, 4'b1000};
    tbl[6] = '{4'b0000, 1'b0, 2'd3, 4'b0000, 4'b1001};
    tbl[7] = '{4'b0000, 1'b1, 2'd0, 4'b0001, 4'b1001};
    tbl[8] = '{4'b0000, 1'b1, 2'd3, 4'b1000, 4'b1000};
    tbl[9] = '{4'b0000, 1'b0, 2'd3, 4'b0000, 4'b0000};

    do_reset();
    chk("reset_valid", 32'(v_rr), 32'd0);
    chk("reset_onehot", 32'(oh_rr), 32'd0);
    chk("reset_idx", 32'(idx_rr), 32'd0);
    chk("reset_drop", 32'(drop_rr), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_out($sformatf("rr_tbl%0d", i), 1'b0, tbl[i].v, tbl[i].idx, tbl[i].oh, tbl[i].pend);
      req_in = tbl[i].req;
    end
    chk("rr_tbl_drop", 32'(drop_rr), 32'd0);

    // Single request, two-cycle latency, one-cycle valid.
    do_reset();
    tick(); req_in = 4'b0100;
    tick(); exp_out("single_c1", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0100); req_in = 4'b0000;
    tick(); exp_out("single_c2", 1'b0, 1'b1, 2'd2, 4'b0100, 4'b0100);
    tick(); exp_out("single_c3", 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0000);

    // Fixed priority: re-request of line 0 in its handshake cycle beats line 2.
    do_reset();
    tick(); req_in = 4'b0001;
    tick(); exp_out("fixed_c1", 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0001); req_in = 4'b0000;
    tick(); exp_out("fixed_c2", 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0001); req_in = 4'b0101;
    tick(); exp_out("fixed_c3", 1'b1, 1'b0, 2'd0, 4'b0000, 4'b0101); req_in = 4'b0000;
    tick(); exp_out("fixed_c4", 1'b1, 1'b1, 2'd0, 4'b0001, 4'b0101);
    tick(); exp_out("fixed_c5", 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0100);
    tick(); exp_out("fixed_c6", 1'b1, 1'b0, 2'd2, 4'b0000, 4'b0000);
    chk("fixed_drop", 32'(drop_fx), 32'd0);

    // Backpressure with duplicate requests on the held line.
    do_reset();
    tick(); req_in = 4'b0010; out_ready = 1'b0;
    tick(); exp_out("bp_c1", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0010); req_in = 4'b0000;
    tick(); exp_out("bp_c2", 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0010); req_in = 4'b0010;
    tick(); exp_out("bp_c3", 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0010);
    tick(); exp_out("bp_c4", 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0010);
    tick(); exp_out("bp_c5", 1'b0, 1'b1, 2'd1, 4'b0010, 4'b0010);
    chk("bp_drop3", 32'(drop_rr), 32'd3);
    req_in = 4'b0000; out_ready = 1'b1;
    tick(); exp_out("bp_c6", 1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000);
    tick(); chk("bp_one_grant", 32'(v_rr), 32'd0);
    chk("bp_drop_hold", 32'(drop_rr), 32'd3);

    // Enable gating, then drop-counter saturation while the grant is held.
    do_reset();
    tick(); en = 1'b0; req_in = 4'b0001;
    tick(); exp_out("en_c1", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0001); req_in = 4'b0000;
    tick(); exp_out("en_c2", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0001);
    tick(); exp_out("en_c3", 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0001); en = 1'b1; out_ready = 1'b0;
    tick(); exp_out("en_c4", 1'b0, 1'b1, 2'd0, 4'b0001, 4'b0001);
    for (int i = 0; i < 300; i++) begin
      req_in = 4'b0001;
      tick();
    end
    req_in = 4'b0000;
    tick(); chk("sat_255", 32'(drop_rr), 32'd255);
    chk("sat_valid_held", 32'(v_rr), 32'd1);
    tick(); chk("sat_hold", 32'(drop_rr), 32'd255);

    // Asynchronous reset mid-transaction with lines 1 and 3 pending.
    do_reset();
    out_ready = 1'b0;
    tick(); req_in = 4'b1010;
    tick(); req_in = 4'b0000;
    tick(); exp_out("pre_rst", 1'b0, 1'b1, 2'd1, 4'b0010, 4'b1010);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(v_rr), 32'd0);
    chk("arst_idx", 32'(idx_rr), 32'd0);
    chk("arst_onehot", 32'(oh_rr), 32'd0);
    chk("arst_pending", 32'(pend_rr), 32'd0);
    chk("arst_drop", 32'(drop_rr), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic against the reference model, with occasional resets.
    out_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      req_in    = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      en        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (i % 701 == 700) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rand_arst_valid", 32'(v_rr), 32'd0);
        chk("rand_arst_pending", 32'(pend_fx), 32'd0);
        @(negedge clk); rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encoder_4x2_rr.md
# encoder_4x2_rr

Registered 4-to-2 request encoder: the inverse of the 2x4 decoder in the dataflow library. It latches one-cycle request pulses on four lines into a pending register. It selects one pending line per transaction by round-robin (or fixed) priority and presents the 2-bit index, plus its one-hot form, on a valid/ready output handshake. Together with decoder_2x4 it forms an encode/decode loopback in the gate-level test environment.

## Interface
- `RR_EN`, default 1: 1 = round-robin priority; 0 = fixed priority, index 0 highest.
- `DROP_W`, default 8: width of the saturating dropped-request counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: enables selection of a new transaction.
- `req_in` in 4: request pulses; each high bit is sampled on the rising edge.
- `out_ready` in 1: consumer accepts `out_idx` this cycle.
- `out_valid` out 1: `out_idx` and `out_onehot` are valid.
- `out_idx` out 2: encoded index of the granted line.
- `out_onehot` out 4: `1 << out_idx` while `out_valid` is high, else 4'b0000.
- `pending` out 4: current pending-request register.
- `drop_cnt` out DROP_W: count of dropped duplicate requests, saturating.

## Operation
- **Reset values.** `pending`=0, `out_valid`=0, `out_idx`=0, `out_onehot`=0, `drop_cnt`=0, round-robin pointer `ptr`=0, state IDLE.
- **Latching.**
  - Each edge: `pending <= (pending & ~clr) | req_in`.
  - `clr` is the one-hot of `out_idx` when `out_valid & out_ready`, else 0.
  - When set and clear hit the same bit, set wins: a re-request of the line being granted stays pending.
- **Dropped requests.**
  - A `req_in` bit whose `pending` bit is 1 and not being cleared this cycle is a drop.
  - `drop_cnt` adds the number of such bits (0-4) per cycle and saturates at all-ones.
- **Selection.**
  - Scan `pending` starting at `ptr`, ascending modulo 4, and take the first set bit.
  - With `RR_EN`=0, `ptr` is held at 0.
- **FSM states.**
  - IDLE: `out_valid`=0.
    - If `en`=1 and `pending`≠0: register the selected index into `out_idx` and go to VALID.
  - VALID: `out_valid`=1; `out_idx` and `out_onehot` are held stable until the handshake.
    - On `out_ready`=1: `ptr <= out_idx+1` (mod 4, wraps 3→0).
    - Let `rem = pending & ~clr`. If `en`=1 and `rem`≠0, load the next selection from `rem`, scanning from the new `ptr`, and stay in VALID (back-to-back).
    - Otherwise go to IDLE.
    - `req_in` arriving in the handshake cycle is not considered until the next edge.
- **`en` deasserted.** A transaction already in VALID is never withdrawn; it completes on `out_ready`. No new selection starts. Requests keep latching.
- **Reset mid-operation.** All registers clear immediately (asynchronously), `out_valid` falls without a handshake, and pending requests are lost.

## Timing
- Request to `out_valid`: a pulse sampled at edge E sets `pending` after E. Selection occurs at E+1, so `out_valid` goes high after E+1. Minimum latency is 2 cycles.
- Back-to-back throughput: one grant per cycle while `out_ready`=1, `en`=1 and lines remain pending.
- Outputs are fully registered; no combinational path from `req_in` or `out_ready` to any output.
- `out_ready` is sampled only while `out_valid`=1 and is ignored in IDLE.
- Reset release: the first selection can start at the first edge after `rst_n` rises.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-transaction with `pending`=4'b1010 → all outputs read 0 immediately, before any clock edge.
- **Single request.** `req_in`=4'b0100 for one cycle, `en`=1, `out_ready`=1 → `out_valid` high 2 cycles later with `out_idx`=2, `out_onehot`=4'b0100. Valid lasts 1 cycle, then `pending`=0.
- **Round-robin.** `req_in`=4'b1111 pulse, `out_ready`=1 → grants 0,1,2,3 on consecutive cycles. Then pulse 4'b1001 → grants 0 then 3 (`ptr` had wrapped to 0).
- **Fixed priority.** With `RR_EN`=0, after index 0 is granted, a re-request on bit 0 arriving in the handshake cycle with bit 2 pending → grants 0 again before 2.
- **Backpressure and duplicates.** `out_ready`=0 while holding `out_idx`=1: `out_idx` stays stable. Pulsing `req_in`=4'b0010 three times → `drop_cnt`=3. Raising `out_ready` → exactly one grant of index 1.
- **Enable and saturation.**
  - `en`=0 with `pending`=4'b0001 → `out_valid` stays 0. Set `en`=1 → valid after 1 edge.
  - `drop_cnt` forced to 255 by repeated duplicates → holds at 255.
